seven_seg_scan_ctrl: RTL

Time-multiplexed scan controller for the 8-digit seven-segment display. It holds a 32-bit display word (8 hex nibbles) and steps through the digits at a programmable dwell rate. For each digit it drives the `num`/`sel` inputs of the combinational segment/anode decoder, plus a per-digit lit enable. New display words enter through a valid/ready handshake and are committed only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/seven_seg_scan_ctrl_if.sv | 10 +
 rtl/seven_seg_scan_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake between a display-word producer and the scan controller.
// The producer holds load_valid/load_data until it sees load_ready at a clock edge.
interface seven_seg_scan_ctrl_if;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: walks digits at a fixed dwell and drives
// the decoder select, nibble and lit enable; new words are committed only at frame boundaries.
module seven_seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    seven_seg_scan_ctrl_if.slave      bus,
    input  logic [7:0]                en_mask,
    input  logic                      blank_lz,
    output logic [3:0]                num,
    output logic [2:0]                sel,
    output logic                      digit_on,
    output logic                      frame_tick
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [23:0] DIV_LAST = 24'(REFRESH_DIV - 1);

    state_t      state, state_nx;
    logic [23:0] div_cnt, div_nx;
    logic [2:0]  sel_nx;
    logic [31:0] active, active_nx;
    logic [31:0] pend;
    logic        pend_valid, pend_valid_nx;
    logic        tick_nx;
    logic        accept;
    logic [31:0] shown;
    logic        lz_blank;
    logic        on_nx;

    assign bus.load_ready = ~pend_valid;
    assign accept         = bus.load_valid & ~pend_valid;

    always_comb begin
        state_nx      = state;
        div_nx        = div_cnt;
        sel_nx        = sel;
        active_nx     = active;
        pend_valid_nx = pend_valid;
        tick_nx       = 1'b0;
        case (state)
            IDLE: begin
                div_nx = '0;
                sel_nx = '0;
                if (pend_valid) begin
                    active_nx     = pend;
                    pend_valid_nx = 1'b0;
                end
                if (run) state_nx = SCAN;
            end
            SCAN: begin
                if (!run) begin
                    state_nx = IDLE;
                    div_nx   = '0;
                    sel_nx   = '0;
                end else if (div_cnt == DIV_LAST) begin
                    div_nx = '0;
                    sel_nx = sel + 3'd1;
                    if (sel == 3'd7) begin
                        tick_nx = 1'b1;
                        if (pend_valid) begin
                            active_nx     = pend;
                            pend_valid_nx = 1'b0;
                        end
                    end
                end else begin
                    div_nx = div_cnt + 24'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Accept and commit never coincide: one needs the buffer empty, the other full.
        if (accept) pend_valid_nx = 1'b1;
    end

    // Outputs are derived from the post-update digit and word so they change together.
    always_comb begin
        shown    = active_nx >> {sel_nx, 2'b00};
        lz_blank = blank_lz && (sel_nx != 3'd0) && (shown == '0);
        on_nx    = (state_nx == SCAN) && en_mask[sel_nx] && !lz_blank;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            sel        <= '0;
            active     <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            num        <= '0;
            digit_on   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nx;
            div_cnt    <= div_nx;
            sel        <= sel_nx;
            active     <= active_nx;
            pend_valid <= pend_valid_nx;
            num        <= shown[3:0];
            digit_on   <= on_nx;
            frame_tick <= tick_nx;
            if (accept) pend <= bus.load_data;
        end
    end

endmodule
